vec_alu_pipe: RTL



---
 rtl/vec_alu_pipe.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/vec_alu_pipe.sv
// Multi-lane pipelined modular vector ALU for the NTT datapath.
// Stage 0 forms products and cheap ops, stage 1 runs the Barrett quotient, stage 2 reduces; extra stages only delay.
module vec_alu_pipe #(
    parameter int W        = 64,
    parameter int LANES    = 4,
    parameter int PIPE_LAT = 4,
    parameter int TAG_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_opcode,
    input  logic [LANES*W-1:0]   in_a,
    input  logic [LANES*W-1:0]   in_b,
    input  logic [LANES*W-1:0]   in_c,
    input  logic [W-1:0]         in_q,
    input  logic [2*W-1:0]       in_mu,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   out_res,
    output logic [TAG_W-1:0]     out_tag,
    output logic [2:0]           out_opcode
);

    localparam int D = PIPE_LAT - 2;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_MAD = 3'b011;
    localparam logic [2:0] OP_NEG = 3'b100;

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] q);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, q}) s = s - {1'b0, q};
        else                s = s;
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] q);
        logic [W:0] d;
        if (a >= b) d = {1'b0, a} - {1'b0, b};
        else        d = {1'b0, a} + {1'b0, q} - {1'b0, b};
        return d[W-1:0];
    endfunction

    function automatic logic [W-1:0] mod_neg(input logic [W-1:0] a, input logic [W-1:0] q);
        logic [W-1:0] n;
        if (a == {W{1'b0}}) n = {W{1'b0}};
        else                n = q - a;
        return n;
    endfunction

    // Barrett quotient estimate: top bits of x*mu, which never exceed x/q
    function automatic logic [W-1:0] barrett_qhat(input logic [2*W-1:0] x, input logic [2*W-1:0] mu);
        logic [4*W-1:0] p;
        p = {{(2*W){1'b0}}, x} * {{(2*W){1'b0}}, mu};
        return p[3*W-1:2*W];
    endfunction

    // Remainder is below 3q, so W+2 low bits suffice and two subtractions finish the job
    function automatic logic [W-1:0] barrett_rem(input logic [W+1:0] x_lo, input logic [W-1:0] qhat,
                                                 input logic [W-1:0] q);
        logic [2*W-1:0] qq;
        logic [W+1:0]   r;
        qq = {{W{1'b0}}, qhat} * {{W{1'b0}}, q};
        r  = x_lo - qq[W+1:0];
        if (r >= {2'b00, q}) r = r - {2'b00, q};
        else                 r = r;
        if (r >= {2'b00, q}) r = r - {2'b00, q};
        else                 r = r;
        return r[W-1:0];
    endfunction

    logic                 advance_s;
    logic [2*W-1:0]       x0_s    [LANES];
    logic [W-1:0]         simp0_s [LANES];
    logic [W-1:0]         qhat_s  [LANES];
    logic [LANES*W-1:0]   res_s;

    logic                 s0_valid_r;
    logic [2:0]           s0_op_r;
    logic [TAG_W-1:0]     s0_tag_r;
    logic [W-1:0]         s0_q_r;
    logic [2*W-1:0]       s0_mu_r;
    logic [2*W-1:0]       s0_x_r    [LANES];
    logic [W-1:0]         s0_simp_r [LANES];

    logic                 s1_valid_r;
    logic [2:0]           s1_op_r;
    logic [TAG_W-1:0]     s1_tag_r;
    logic [W-1:0]         s1_q_r;
    logic [W+1:0]         s1_xlo_r  [LANES];
    logic [W-1:0]         s1_qhat_r [LANES];
    logic [W-1:0]         s1_simp_r [LANES];

    logic                 dly_valid_r [D];
    logic [2:0]           dly_op_r    [D];
    logic [TAG_W-1:0]     dly_tag_r   [D];
    logic [LANES*W-1:0]   dly_res_r   [D];

    assign advance_s  = !dly_valid_r[D-1] || out_ready;
    assign in_ready   = advance_s;
    assign out_valid  = dly_valid_r[D-1];
    assign out_opcode = dly_op_r[D-1];
    assign out_tag    = dly_tag_r[D-1];
    assign out_res    = dly_res_r[D-1];

    // Per-lane product (plus addend for MAD) and the single-step modular ops
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            x0_s[i] = ({{W{1'b0}}, in_a[i*W +: W]} * {{W{1'b0}}, in_b[i*W +: W]})
                    + ((in_opcode == OP_MAD) ? {{W{1'b0}}, in_c[i*W +: W]} : {(2*W){1'b0}});
            simp0_s[i] = {W{1'b0}};
            case (in_opcode)
                OP_ADD:  simp0_s[i] = mod_add(in_a[i*W +: W], in_b[i*W +: W], in_q);
                OP_SUB:  simp0_s[i] = mod_sub(in_a[i*W +: W], in_b[i*W +: W], in_q);
                OP_NEG:  simp0_s[i] = mod_neg(in_a[i*W +: W], in_q);
                default: simp0_s[i] = {W{1'b0}};
            endcase
        end
    end

    // Barrett quotient per lane from stage 0
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            qhat_s[i] = barrett_qhat(s0_x_r[i], s0_mu_r);
        end
    end

    // Final per-lane result select; reserved opcodes already carry zero in simp
    always_comb begin
        res_s = {(LANES*W){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if ((s1_op_r == OP_MUL) || (s1_op_r == OP_MAD)) begin
                res_s[i*W +: W] = barrett_rem(s1_xlo_r[i], s1_qhat_r[i], s1_q_r);
            end else begin
                res_s[i*W +: W] = s1_simp_r[i];
            end
        end
    end

    // Stage 0 register: beat capture with per-beat modulus, mu, opcode and tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid_r <= 1'b0;
            s0_op_r    <= 3'b000;
            s0_tag_r   <= {TAG_W{1'b0}};
            s0_q_r     <= {W{1'b0}};
            s0_mu_r    <= {(2*W){1'b0}};
            for (int i = 0; i < LANES; i++) begin
                s0_x_r[i]    <= {(2*W){1'b0}};
                s0_simp_r[i] <= {W{1'b0}};
            end
        end else if (advance_s) begin
            s0_valid_r <= in_valid;
            if (in_valid) begin
                s0_op_r  <= in_opcode;
                s0_tag_r <= in_tag;
                s0_q_r   <= in_q;
                s0_mu_r  <= in_mu;
                for (int i = 0; i < LANES; i++) begin
                    s0_x_r[i]    <= x0_s[i];
                    s0_simp_r[i] <= simp0_s[i];
                end
            end
        end
    end

    // Stage 1 register: quotient estimate plus the low bits of x needed for the remainder
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= 3'b000;
            s1_tag_r   <= {TAG_W{1'b0}};
            s1_q_r     <= {W{1'b0}};
            for (int i = 0; i < LANES; i++) begin
                s1_xlo_r[i]  <= {(W+2){1'b0}};
                s1_qhat_r[i] <= {W{1'b0}};
                s1_simp_r[i] <= {W{1'b0}};
            end
        end else if (advance_s) begin
            s1_valid_r <= s0_valid_r;
            if (s0_valid_r) begin
                s1_op_r  <= s0_op_r;
                s1_tag_r <= s0_tag_r;
                s1_q_r   <= s0_q_r;
                for (int i = 0; i < LANES; i++) begin
                    s1_xlo_r[i]  <= s0_x_r[i][W+1:0];
                    s1_qhat_r[i] <= qhat_s[i];
                    s1_simp_r[i] <= s0_simp_r[i];
                end
            end
        end
    end

    // Result stage followed by pure delay stages; the last one drives the outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < D; k++) begin
                dly_valid_r[k] <= 1'b0;
                dly_op_r[k]    <= 3'b000;
                dly_tag_r[k]   <= {TAG_W{1'b0}};
                dly_res_r[k]   <= {(LANES*W){1'b0}};
            end
        end else if (advance_s) begin
            dly_valid_r[0] <= s1_valid_r;
            if (s1_valid_r) begin
                dly_op_r[0]  <= s1_op_r;
                dly_tag_r[0] <= s1_tag_r;
                dly_res_r[0] <= res_s;
            end
            for (int k = 1; k < D; k++) begin
                dly_valid_r[k] <= dly_valid_r[k-1];
                if (dly_valid_r[k-1]) begin
                    dly_op_r[k]  <= dly_op_r[k-1];
                    dly_tag_r[k] <= dly_tag_r[k-1];
                    dly_res_r[k] <= dly_res_r[k-1];
                end
            end
        end
    end

endmodule
